// File: rtl/imem_loader.sv
// imem_loader: loads instruction memory from a byte stream.
//
// Gathers big-endian 32-bit words from a byte source and writes them to consecutive
// word addresses starting at BASE_ADDR. While a session is running the CPU's PC and
// IF/ID stage are held so that partially loaded code cannot be fetched. When the
// session ends, the PC is pulsed to restart at BASE_ADDR.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add a trailing checksum byte.
// This byte is compared with the XOR of all data bytes. A mismatch sets the sticky
// error flag and suppresses pc_restart.
//
// Parameters:
//   ADDR_WIDTH  word-address width of the instruction memory (depth 2^ADDR_WIDTH)
//   BASE_ADDR   byte address of the first loaded word (word aligned)
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, word_count session request and word count (sampled only when idle)
//   byte_valid/data   byte source
//   byte_ready        loader takes a byte this cycle (state decode only)
//   mem_we/addr/wdata instruction memory write port (registered)
//   cpu_hold, busy    session in progress (state decode)
//   pc_restart, done  one-cycle end-of-session pulses (registered)
//   error             sticky bad-count / checksum-mismatch flag (registered)

module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] word_count,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                cpu_hold,
  output logic                pc_restart,
  output logic                busy,
  output logic                done,
  output logic                error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StRecv, StWrite, StCheck, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone} state_e;
`endif

  // Largest legal count is the full memory depth, 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] MaxCount = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] IndexOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e              state_q;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] index_q;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         partial_q;
  logic                mem_we_q;
  logic [31:0]         mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                pc_restart_q;
  logic                done_q;
  logic                error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          xor_q;
`endif

  logic                count_ok;
  logic                byte_accept;
  logic [ADDR_WIDTH:0] index_inc;
  logic [31:0]         word_offset;

  assign count_ok    = (word_count != '0) && (word_count <= MaxCount);
  assign byte_accept = byte_valid && byte_ready;
  assign index_inc   = index_q + IndexOne;
  // The byte offset of the current word. The carry out of the 32-bit add is discarded.
  assign word_offset = 32'({index_q, 2'b00});

  // Handshake and hold signals decode the current state only. As a result, byte_ready
  // never depends on byte_valid.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      StRecv: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      StWrite: busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign cpu_hold = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      count_q      <= '0;
      index_q      <= '0;
      byte_cnt_q   <= '0;
      partial_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pc_restart_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      // Strobes last one cycle unless a transition below sets them again.
      mem_we_q     <= 1'b0;
      pc_restart_q <= 1'b0;
      done_q       <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (count_ok) begin
              count_q    <= word_count;
              error_q    <= 1'b0;
              index_q    <= '0;
              byte_cnt_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              xor_q      <= '0;
`endif
              state_q    <= StRecv;
            end else begin
              // Bad count: finish at once without writing anything.
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end

        StRecv: begin
          if (byte_accept) begin
            partial_q  <= {partial_q[15:0], byte_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= xor_q ^ byte_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              // The first byte received is the most significant byte of the word.
              mem_we_q    <= 1'b1;
              mem_addr_q  <= BASE_ADDR + word_offset;
              mem_wdata_q <= {partial_q, byte_data};
              state_q     <= StWrite;
            end
          end
        end

        StWrite: begin
          index_q <= index_inc;
          if (index_inc == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q      <= StCheck;
`else
            done_q       <= 1'b1;
            pc_restart_q <= !error_q;
            state_q      <= StDone;
`endif
          end else begin
            state_q <= StRecv;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        StCheck: begin
          if (byte_accept) begin
            if (byte_data != xor_q) begin
              error_q <= 1'b1;
            end
            pc_restart_q <= !error_q && (byte_data == xor_q);
            done_q       <= 1'b1;
            state_q      <= StDone;
          end
        end
`endif

        StDone: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign pc_restart = pc_restart_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes instruction memory from a byte stream, the write-side counterpart to the pipeline's instruction fetch reader. It sits between a host byte source (test bench, UART receiver, or debug port) and the instruction memory write port. It assembles big-endian 32-bit instruction words and writes them to consecutive word addresses. While loading, it holds the PC and IF/ID stage so the CPU cannot fetch partially loaded code.

## Interface
- `ADDR_WIDTH`, 8, instruction memory word-address width; depth = 2^ADDR_WIDTH words
- `BASE_ADDR`, 32'h0, byte address of the first loaded word; word aligned
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a load session; sampled only in IDLE
- `word_count`  in  ADDR_WIDTH+1  number of words to load; latched on accepted `start`
- `byte_valid`  in  1  source has a byte
- `byte_data`  in  8  byte value
- `byte_ready`  out  1  loader accepts a byte this cycle
- `mem_we`  out  1  instruction memory write enable
- `mem_addr`  out  32  byte address of the write
- `mem_wdata`  out  32  assembled instruction word
- `cpu_hold`  out  1  drives the PC hold and IF/ID hold inputs
- `pc_restart`  out  1  one-cycle pulse; the PC reloads `BASE_ADDR`
- `busy`  out  1  session in progress
- `done`  out  1  one-cycle session-complete pulse
- `error`  out  1  sticky; set on a bad count or checksum mismatch

## Operation
- States are IDLE, RECV, WRITE, CHECK (macro only), and DONE.
- **IDLE:** all handshake and strobe outputs are 0.
  - If `start`=1 and 1 ≤ `word_count` ≤ 2^ADDR_WIDTH: latch the count, clear `error`, zero the word index, byte counter, and checksum, then go to RECV.
  - If `start`=1 with any other count: set `error` and go to DONE. No writes occur.
- **RECV:** `byte_ready`=1.
  - A byte is accepted when `byte_valid` && `byte_ready` at the edge.
  - Byte k (k = 0..3) goes to bits [31-8k:24-8k]. Byte 0 is the MSB.
  - When byte 3 is accepted, go to WRITE.
- **WRITE:** for one cycle, `mem_we`=1, `mem_addr`=`BASE_ADDR` + 4·index, `mem_wdata`=assembled word, `byte_ready`=0.
  - Then increment the index.
  - If index+1 = count, go to CHECK (macro defined) or DONE. Otherwise go to RECV.
- **DONE:** for one cycle, `done`=1, `pc_restart`=1 (only if `error`=0), `busy`=0, `cpu_hold`=0. Then go to IDLE.
- `busy` and `cpu_hold` are 1 exactly in RECV, WRITE, and CHECK.
- `start` outside IDLE is ignored.
- The index counter is ADDR_WIDTH+1 bits wide, so it cannot wrap for a legal count.
- `mem_addr` arithmetic is 32-bit and discards carry.

## Timing
- Reset value of every output is 0, including `mem_addr`, `mem_wdata`, and `error`. State is IDLE.
- Reset mid-session aborts immediately:
  - words already written stay in memory;
  - the partial word is discarded;
  - `done` is not pulsed.
- Accepted `start` at edge N puts the block in RECV in cycle N+1.
- With no source stalls, N words take exactly 5N cycles from the first RECV cycle to the DONE cycle, or 5N+1 with the checksum enabled.
- A bad count gives DONE in the cycle after the `start` edge.
- `byte_ready` does not depend on `byte_valid`, so there is no combinational loop.
- Source stalls (`byte_valid`=0) keep the state and partial word unchanged.
- All outputs are registered except `byte_ready`, `busy`, and `cpu_hold`, which decode the current state.

## Configuration
- Macro `IMEM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - a running XOR over every accepted data byte is kept;
  - after the last WRITE the block enters CHECK with `byte_ready`=1 and accepts one checksum byte;
  - a mismatch sets `error`; the block then goes to DONE and `pc_restart` is suppressed.
- **Undefined:** the CHECK state and the XOR register do not exist; after the last WRITE the block goes directly to DONE.

## Test plan
- **Reset:** assert `reset` for 2 cycles, then idle 5 cycles → every output is 0 and `byte_ready` stays 0.
- **Two-word load:**
  - Stimulus: `BASE_ADDR`=0, `word_count`=2, bytes 20 08 00 05 00 00 00 00 presented back-to-back.
  - Required response:
    - `mem_we` pulses twice: (0x0, 0x20080005) and (0x4, 0x00000000);
    - `done` and `pc_restart` are high 10 cycles after the first RECV cycle;
    - `cpu_hold` is high throughout RECV/WRITE.
- **Stalls:** same as the two-word load with `byte_valid` dropped for 3 cycles between bytes 1 and 2 and bytes 5 and 6 → identical writes, exactly 2 `mem_we` pulses, `done` 6 cycles later.
- **Bad count:** `word_count`=0, and separately 2^ADDR_WIDTH+1 → no `mem_we`; `done`=1 and `error`=1 in the cycle after `start`; `pc_restart`=0.
- **Reset mid-load:** assert `reset` after 6 bytes of a 2-word load → only (0x0, 0x20080005) is written and all outputs return to 0. A new `start` then writes again from 0x0.
- **Checksum (macro defined):**
  - bytes 01 02 03 04 followed by checksum 04 → `error`=0 and `pc_restart`=1;
  - checksum 05 → `error`=1 and `pc_restart`=0.
